// File: rtl/nec_ir_receiver.sv
// NEC infrared frame decoder: measures pulse/space widths on the synchronized
// IR line and commits 32-bit frames, flagging repeat codes and malformed frames.
module nec_ir_receiver #(
  parameter int TICK_DIV       = 500,
  parameter bit CHECK_DATA_INV = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iIR,
  output logic        get_flag,
  output logic [15:0] ir_addr,
  output logic [15:0] ir_data,
  output logic        repeat_pulse,
  output logic        frame_err
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [10:0] W_LEAD_MIN  = 11'd800;
  localparam logic [10:0] W_LEAD_MAX  = 11'd1000;
  localparam logic [10:0] W_FRAME_MIN = 11'd400;
  localparam logic [10:0] W_FRAME_MAX = 11'd500;
  localparam logic [10:0] W_REP_MIN   = 11'd200;
  localparam logic [10:0] W_REP_MAX   = 11'd250;
  localparam logic [10:0] W_SHORT_MIN = 11'd40;
  localparam logic [10:0] W_SHORT_MAX = 11'd70;
  localparam logic [10:0] W_ONE_MIN   = 11'd140;
  localparam logic [10:0] W_ONE_MAX   = 11'd190;
  localparam logic [10:0] SEG_SAT     = 11'd2047;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP
  } state_t;

  state_t        state, state_n;
  logic          sync1, sync2, sync3;
  logic          fall, rise;
  logic [PW-1:0] presc;
  logic          tick;
  logic [10:0]   seg;
  logic [10:0]   seg_max;
  logic          timeout;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [31:0]   shreg, shreg_n;
  logic          rep, rep_n;
  logic          commit, rep_set, err_set;

  function automatic logic in_win(input logic [10:0] val, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  assign fall = sync3 & ~sync2;
  assign rise = ~sync3 & sync2;
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= iIR;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Every edge restarts the width measurement; seg saturates so long idles stay bounded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      seg   <= '0;
    end else if (fall || rise) begin
      presc <= '0;
      seg   <= '0;
    end else if (tick) begin
      presc <= '0;
      if (seg != SEG_SAT) seg <= seg + 11'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    seg_max = SEG_SAT;
    case (state)
      LEAD_LOW:      seg_max = W_LEAD_MAX;
      LEAD_HIGH:     seg_max = W_FRAME_MAX;
      BIT_LOW, STOP: seg_max = W_SHORT_MAX;
      BIT_HIGH:      seg_max = W_ONE_MAX;
      default:       seg_max = SEG_SAT;
    endcase
  end

  assign timeout = (state != IDLE) && (seg > seg_max);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rep_n     = rep;
    commit    = 1'b0;
    rep_set   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_n = LEAD_LOW;
      end
      // A leader that never qualified is treated as noise, never as a frame error.
      LEAD_LOW: begin
        if (timeout) state_n = IDLE;
        else if (rise) state_n = in_win(seg, W_LEAD_MIN, W_LEAD_MAX) ? LEAD_HIGH : IDLE;
      end
      LEAD_HIGH: begin
        if (timeout) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          if (in_win(seg, W_FRAME_MIN, W_FRAME_MAX)) begin
            state_n   = BIT_LOW;
            bit_cnt_n = '0;
            shreg_n   = '0;
            rep_n     = 1'b0;
          end else if (in_win(seg, W_REP_MIN, W_REP_MAX)) begin
            state_n = STOP;
            rep_n   = 1'b1;
          end else begin
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BIT_LOW: begin
        if (timeout || (rise && !in_win(seg, W_SHORT_MIN, W_SHORT_MAX))) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (rise) begin
          state_n = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        if (timeout) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          if (in_win(seg, W_SHORT_MIN, W_SHORT_MAX) || in_win(seg, W_ONE_MIN, W_ONE_MAX)) begin
            shreg_n = {in_win(seg, W_ONE_MIN, W_ONE_MAX), shreg[31:1]};
            if (bit_cnt == 5'd31) begin
              state_n = STOP;
              rep_n   = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
              state_n   = BIT_LOW;
            end
          end else begin
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
      end
      STOP: begin
        if (timeout || (rise && !in_win(seg, W_SHORT_MIN, W_SHORT_MAX))) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (rise) begin
          state_n = IDLE;
          if (rep) rep_set = 1'b1;
          else if (!CHECK_DATA_INV || (shreg[31:24] == ~shreg[23:16])) commit = 1'b1;
          else err_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      rep     <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      rep     <= rep_n;
    end
  end

  // Address, data and the toggle flag move together so the consumer sees a coherent word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      get_flag     <= 1'b0;
      ir_addr      <= '0;
      ir_data      <= '0;
      repeat_pulse <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      repeat_pulse <= rep_set;
      frame_err    <= err_set;
      if (commit) begin
        get_flag <= ~get_flag;
        ir_addr  <= shreg[15:0];
        ir_data  <= shreg[31:16];
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Scoreboard bench for nec_ir_receiver: one instance with the data inversion check
// enabled and one with it disabled, both driven from the same IR line.
`timescale 1ns/1ps
module tb_nec_ir_receiver;

  localparam int TICK = 1;
  localparam int K_COMMIT = 0;
  localparam int K_REP    = 1;
  localparam int K_ERR    = 2;
  localparam int K_NONE   = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
    int flag;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iIR = 1'b1;
  logic [1:0]  gf, rp, fe;
  logic [15:0] addr0, addr1, data0, data1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   model_addr[2];
  int   model_data[2];
  int   model_flag[2];
  logic [1:0] prev_flag = 2'b00;

  nec_ir_receiver #(.TICK_DIV(TICK), .CHECK_DATA_INV(1'b1)) dut_chk (
    .clk(clk), .reset_n(reset_n), .iIR(iIR),
    .get_flag(gf[0]), .ir_addr(addr0), .ir_data(data0),
    .repeat_pulse(rp[0]), .frame_err(fe[0])
  );

  nec_ir_receiver #(.TICK_DIV(TICK), .CHECK_DATA_INV(1'b0)) dut_nochk (
    .clk(clk), .reset_n(reset_n), .iIR(iIR),
    .get_flag(gf[1]), .ir_addr(addr1), .ir_data(data1),
    .repeat_pulse(rp[1]), .frame_err(fe[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic push_exp(input int d, input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.addr = model_addr[d];
    e.data = model_data[d];
    e.flag = model_flag[d];
    e.cyc  = at;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic monitor_one(input int d, input logic flag, input logic rp_i, input logic fe_i,
                             input logic [15:0] a, input logic [15:0] dt);
    exp_t e;
    int   kind;
    int   qsize;
    if (!reset_n) begin
      prev_flag[d] = flag;
      return;
    end
    kind = K_NONE;
    if (flag != prev_flag[d]) kind = K_COMMIT;
    else if (rp_i) kind = K_REP;
    else if (fe_i) kind = K_ERR;
    prev_flag[d] = flag;
    if (kind == K_NONE) return;
    qsize = (d == 0) ? q0.size() : q1.size();
    if (qsize == 0) begin
      check_output($sformatf("unexpected_event_d%0d", d), kind, K_NONE);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    check_output($sformatf("kind_d%0d", d), kind, e.kind);
    check_output($sformatf("pulse_overlap_d%0d", d), int'(rp_i & fe_i), 0);
    if (e.cyc >= 0) check_output($sformatf("latency_d%0d", d), cyc, e.cyc);
    check_output($sformatf("ir_addr_d%0d", d), int'(a), e.addr);
    check_output($sformatf("ir_data_d%0d", d), int'(dt), e.data);
    check_output($sformatf("get_flag_d%0d", d), int'(flag), e.flag);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_one(0, gf[0], rp[0], fe[0], addr0, data0);
      monitor_one(1, gf[1], rp[1], fe[1], addr1, data1);
    end
  end

  task automatic drive(input logic lvl, input int ticks);
    iIR = lvl;
    repeat (ticks * TICK) @(negedge clk);
  endtask

  task automatic send_leader(input int high_ticks);
    drive(1'b0, 900);
    drive(1'b1, high_ticks);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 56);
      drive(1'b1, w[i] ? 169 : 56);
    end
  endtask

  task automatic drain_check();
    check_output("pending_d0", q0.size(), 0);
    check_output("pending_d1", q1.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_flag_d0"}, int'(gf[0]), 0);
    check_output({tag, "_flag_d1"}, int'(gf[1]), 0);
    check_output({tag, "_addr_d0"}, int'(addr0), 0);
    check_output({tag, "_addr_d1"}, int'(addr1), 0);
    check_output({tag, "_data_d0"}, int'(data0), 0);
    check_output({tag, "_data_d1"}, int'(data1), 0);
    check_output({tag, "_pulses"}, int'({rp, fe}), 0);
  endtask

  task automatic apply_frame(input logic [31:0] w, input int exp_addr, input int exp_data,
                             input bit inv_ok);
    send_leader(450);
    send_bits(w, 32);
    drive(1'b0, 56);
    for (int d = 0; d < 2; d++) begin
      if (d == 1 || inv_ok) begin
        model_flag[d] = model_flag[d] ^ 1;
        model_addr[d] = exp_addr;
        model_data[d] = exp_data;
        push_exp(d, K_COMMIT, cyc + 3);
      end else begin
        push_exp(d, K_ERR, cyc + 3);
      end
    end
    drive(1'b1, 300);
    drain_check();
  endtask

  task automatic apply_repeat();
    send_leader(225);
    drive(1'b0, 56);
    push_exp(0, K_REP, cyc + 3);
    push_exp(1, K_REP, cyc + 3);
    drive(1'b1, 300);
    drain_check();
  endtask

  task automatic apply_truncated(input logic [31:0] w);
    send_leader(450);
    send_bits(w, 16);
    drive(1'b0, 56);
    push_exp(0, K_ERR, -1);
    push_exp(1, K_ERR, -1);
    drive(1'b1, 2500);
    drain_check();
  endtask

  task automatic apply_glitch();
    drive(1'b0, 10);
    drive(1'b1, 200);
    drain_check();
  endtask

  task automatic apply_reset_mid_frame(input logic [31:0] w);
    send_leader(450);
    send_bits(w, 20);
    drive(1'b0, 20);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      model_flag[d] = 0;
      model_addr[d] = 0;
      model_data[d] = 0;
    end
    drive(1'b0, 30);
    drive(1'b1, 300);
    drain_check();
  endtask

  initial begin
    #(150000 * 10);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      model_flag[d] = 0;
      model_addr[d] = 0;
      model_data[d] = 0;
    end
    iIR     = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    drive(1'b1, 100);
    check_all_zero("post_reset");

    apply_glitch();
    apply_frame(32'hBA45_FF00, 'hFF00, 'hBA45, 1'b1);
    apply_frame(32'hE916_FE01, 'hFE01, 'hE916, 1'b1);
    apply_repeat();
    apply_frame(32'h4545_FF00, 'hFF00, 'h4545, 1'b0);
    apply_truncated(32'hBA45_FF00);
    apply_frame(32'hE916_FE01, 'hFE01, 'hE916, 1'b1);
    apply_reset_mid_frame(32'hBA45_FF00);
    apply_frame(32'hBA45_FF00, 'hFF00, 'hBA45, 1'b1);
    check_output("final_flag_d0", int'(gf[0]), 1);
    check_output("final_flag_d1", int'(gf[1]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
